// File: rtl/types.sv
// Shared front-end types: the imem response packet and fetch-queue instantiation defaults.
package types;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } imem_pkt_t;

  localparam int FQ_DEPTH_LOG2 = 3;
  localparam int FQ_ENQ_W      = 2;
  localparam int FQ_DEQ_W      = 2;

endpackage

// File: rtl/fq_enq_compact.sv
// Prefix-sum compaction of the enqueue lane mask: each valid lane gets the slot offset
// equal to the number of valid lanes below it, so only valid packets consume slots.
module fq_enq_compact #(
  parameter int ENQ_W = 2,
  parameter int OW    = $clog2(ENQ_W + 1)
) (
  input  logic [ENQ_W-1:0]         enq_valid,
  output logic [ENQ_W-1:0][OW-1:0] wr_off,
  output logic [ENQ_W-1:0]         wr_en,
  output logic [OW-1:0]            pop
);

  logic [OW-1:0] acc;

  always_comb begin
    acc    = '0;
    wr_off = '0;
    wr_en  = '0;
    for (int i = 0; i < ENQ_W; i++) begin
      wr_off[i] = acc;
      wr_en[i]  = enq_valid[i];
      acc       = acc + OW'(enq_valid[i]);
    end
    pop = acc;
  end

endmodule

// File: rtl/fetch_queue_multi.sv
// Multi-lane instruction fetch queue: up to ENQ_W packets in, up to DEQ_W oldest packets
// presented in program order, with clamped partial dequeue and single-cycle flush.
module fetch_queue_multi
  import types::*;
#(
  parameter int DEPTH_LOG2   = FQ_DEPTH_LOG2,
  parameter int ENQ_W        = FQ_ENQ_W,
  parameter int DEQ_W        = FQ_DEQ_W,
  parameter int AFULL_THRESH = (2 ** DEPTH_LOG2) - ENQ_W,
  localparam int DEPTH       = 2 ** DEPTH_LOG2,
  localparam int PW          = DEPTH_LOG2 + 1,
  localparam int DW          = $clog2(DEQ_W + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [ENQ_W-1:0]            enq_valid,
  input  imem_pkt_t [ENQ_W-1:0]       din,
  output logic                        enq_rdy,
  input  logic [DW-1:0]               deq_cnt,
  output imem_pkt_t [DEQ_W-1:0]       dout,
  output logic [DEQ_W-1:0]            dout_valid,
  output logic [PW-1:0]               q_count,
  output logic                        q_empty,
  output logic                        q_almost_full
);

  // Handshake: enqueue is all-or-nothing -- on an edge with enq_rdy high, every set
  // enq_valid lane is written; with enq_rdy low the whole group is dropped and upstream
  // must hold it. Dequeue has no ready: deq_cnt heads are consumed, clamped to q_count.

  localparam int OW = $clog2(ENQ_W + 1);
  localparam logic [PW-1:0] RDY_MAX   = PW'(DEPTH - ENQ_W);
  localparam logic [PW-1:0] AFULL_LIM = PW'(AFULL_THRESH);

  if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 6) begin : g_bad_depth
    $error("fetch_queue_multi: DEPTH_LOG2 out of range 1..6");
  end
  if (ENQ_W < 1 || ENQ_W > DEPTH || DEQ_W < 1 || DEQ_W > DEPTH) begin : g_bad_lanes
    $error("fetch_queue_multi: ENQ_W and DEQ_W must lie in 1..DEPTH");
  end
  if (AFULL_THRESH < 0 || AFULL_THRESH > DEPTH) begin : g_bad_afull
    $error("fetch_queue_multi: AFULL_THRESH must lie in 0..DEPTH");
  end

  imem_pkt_t       mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;

  logic [ENQ_W-1:0][OW-1:0]         wr_off;
  logic [ENQ_W-1:0]                 wr_en;
  logic [OW-1:0]                    pop;
  logic [ENQ_W-1:0][DEPTH_LOG2-1:0] widx;
  logic                             enq_fire;
  logic [PW-1:0]                    deq_req;
  logic [PW-1:0]                    deq_eff;

  fq_enq_compact #(.ENQ_W(ENQ_W), .OW(OW)) u_compact (
    .enq_valid (enq_valid),
    .wr_off    (wr_off),
    .wr_en     (wr_en),
    .pop       (pop)
  );

  // The wrap bit makes tail - head exact across DEPTH, so full and empty differ.
  assign q_count       = tail - head;
  assign q_empty       = (q_count == '0);
  assign enq_rdy       = (q_count <= RDY_MAX);
  assign q_almost_full = (q_count >= AFULL_LIM);
  assign enq_fire      = enq_rdy & (|enq_valid) & ~flush;
  assign deq_req       = PW'(deq_cnt);
  assign deq_eff       = (deq_req > q_count) ? q_count : deq_req;

  always_comb begin
    widx = '0;
    for (int i = 0; i < ENQ_W; i++) begin
      widx[i] = tail[DEPTH_LOG2-1:0] + DEPTH_LOG2'(wr_off[i]);
    end
  end

  always_comb begin
    dout       = '0;
    dout_valid = '0;
    for (int j = 0; j < DEQ_W; j++) begin
      dout[j]       = mem[head[DEPTH_LOG2-1:0] + DEPTH_LOG2'(j)];
      dout_valid[j] = (q_count > PW'(j));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      head <= tail;
    end else begin
      if (enq_fire) begin
        for (int i = 0; i < ENQ_W; i++) begin
          if (wr_en[i]) begin
            mem[widx[i]] <= din[i];
          end
        end
        tail <= tail + PW'(pop);
      end
      head <= head + deq_eff;
    end
  end

endmodule

// File: tb/tb_fetch_queue_multi.sv
// Bench for fetch_queue_multi (DEPTH 8, 2 enqueue lanes, 2 dequeue lanes, afull at 6):
// directed scenarios plus random traffic against a packet-queue reference model.
module tb_fetch_queue_multi;
  import types::*;

  localparam int DEPTH = 8;
  localparam int ENQ_W = 2;
  localparam int DEQ_W = 2;
  localparam int AFULL = 6;

  logic                  clk;
  logic                  rst;
  logic                  flush;
  logic [ENQ_W-1:0]      enq_valid;
  imem_pkt_t [ENQ_W-1:0] din;
  logic                  enq_rdy;
  logic [1:0]            deq_cnt;
  imem_pkt_t [DEQ_W-1:0] dout;
  logic [DEQ_W-1:0]      dout_valid;
  logic [3:0]            q_count;
  logic                  q_empty;
  logic                  q_almost_full;

  logic [63:0] exp_q[$];
  int n_vec;
  int n_err;

  fetch_queue_multi #(
    .DEPTH_LOG2   (3),
    .ENQ_W        (ENQ_W),
    .DEQ_W        (DEQ_W),
    .AFULL_THRESH (AFULL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .enq_valid     (enq_valid),
    .din           (din),
    .enq_rdy       (enq_rdy),
    .deq_cnt       (deq_cnt),
    .dout          (dout),
    .dout_valid    (dout_valid),
    .q_count       (q_count),
    .q_empty       (q_empty),
    .q_almost_full (q_almost_full)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare every output against the model at the negedge before the next edge.
  task automatic check_outputs();
    int n;
    n = exp_q.size();
    check("q_count", 64'(q_count), 64'(n));
    check("q_empty", 64'(q_empty), 64'(n == 0));
    check("q_almost_full", 64'(q_almost_full), 64'(n >= AFULL));
    check("enq_rdy", 64'(enq_rdy), 64'((DEPTH - n) >= ENQ_W));
    for (int j = 0; j < DEQ_W; j++) begin
      check($sformatf("dout_valid[%0d]", j), 64'(dout_valid[j]), 64'(n > j));
      if (n > j) check($sformatf("dout[%0d]", j), 64'(dout[j]), exp_q[j]);
    end
  endtask

  // Driver: apply one cycle of inputs, check, advance the model, clock the edge.
  task automatic cycle(input logic r, input logic f, input logic [1:0] v,
                       input logic [63:0] p0, input logic [63:0] p1, input logic [1:0] d);
    int n;
    int k;
    bit rdy;
    rst       = r;
    flush     = f;
    enq_valid = v;
    din[0]    = imem_pkt_t'(p0);
    din[1]    = imem_pkt_t'(p1);
    deq_cnt   = d;
    @(negedge clk);
    check_outputs();
    n   = exp_q.size();
    rdy = (DEPTH - n) >= ENQ_W;
    if (r || f) begin
      exp_q.delete();
    end else begin
      k = (int'(d) > n) ? n : int'(d);
      repeat (k) void'(exp_q.pop_front());
      if (rdy && v != 2'b00) begin
        if (v[0]) exp_q.push_back(p0);
        if (v[1]) exp_q.push_back(p1);
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; flush = 1'b0; enq_valid = '0; din = '0; deq_cnt = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();

    // reset then idle: storage cleared, so dout reads zero
    @(negedge clk);
    check("reset_dout", 64'(dout), 64'd0);
    cycle(0, 0, 2'b00, 0, 0, 0);
    cycle(0, 0, 2'b00, 0, 0, 0);

    // fill A..H, then a dropped fifth enqueue (I, J)
    for (int i = 0; i < 4; i++) cycle(0, 0, 2'b11, 64'hA0 + 64'(2*i), 64'hA1 + 64'(2*i), 0);
    cycle(0, 0, 2'b11, 64'hEE0, 64'hEE1, 0);
    check("fill_count", 64'(q_count), 64'd8);
    check("fill_head", 64'(dout), {64'hA1, 64'hA0});

    // drain, sparse mask 2'b10 then 2'b01
    cycle(0, 1, 2'b00, 0, 0, 0);
    cycle(0, 0, 2'b10, 64'hDEAD, 64'h1111, 0);
    cycle(0, 0, 2'b01, 64'h2222, 64'hBEEF, 0);
    check("sparse_count", 64'(q_count), 64'd2);
    check("sparse_order", 64'(dout), {64'h2222, 64'h1111});

    // fill to 7, then concurrent enq/deq across the wrap
    cycle(0, 0, 2'b11, rnd64(), rnd64(), 0);
    cycle(0, 0, 2'b11, rnd64(), rnd64(), 0);
    cycle(0, 0, 2'b01, rnd64(), rnd64(), 0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 2'b11, rnd64(), rnd64(), 2);

    // over-dequeue down to one entry then past it
    while (exp_q.size() > 1) cycle(0, 0, 2'b00, 0, 0, 1);
    cycle(0, 0, 2'b00, 0, 0, 2);
    cycle(0, 0, 2'b00, 0, 0, 0);

    // flush collision at count 5, then (P, Q)
    cycle(0, 0, 2'b11, rnd64(), rnd64(), 0);
    cycle(0, 0, 2'b11, rnd64(), rnd64(), 0);
    cycle(0, 0, 2'b01, rnd64(), rnd64(), 0);
    cycle(0, 1, 2'b11, rnd64(), rnd64(), 2);
    check("flush_empty", 64'(q_empty), 64'd1);
    cycle(0, 0, 2'b11, 64'h5050, 64'h5151, 0);
    check("flush_then_pq", 64'(dout), {64'h5151, 64'h5050});

    // random traffic with occasional flush and reset
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5,
            2'($urandom_range(0, 3)), rnd64(), rnd64(), 2'($urandom_range(0, 2)));
    end
    @(negedge clk);
    check_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
